// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory handshake plus the decoder-facing slot.
interface fetch_unit_if #(
   parameter int unsigned ADDR_W = 16
);
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic [15:0]       mem_rdata;
   logic              mem_ready;
   logic              stall;
   logic [15:0]       instr;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_valid;

   modport master (
      output mem_addr, mem_rd, instr, instr_pc, instr_valid,
      input  mem_rdata, mem_ready, stall
   );

   modport slave (
      input  mem_addr, mem_rd, instr, instr_pc, instr_valid,
      output mem_rdata, mem_ready, stall
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches 16-bit words over an
// address/ready handshake and presents one instruction at a time in a
// registered slot, with redirect flush and halt parking.
module fetch_unit #(
   parameter int unsigned           ADDR_W   = 16,
   parameter logic [ADDR_W-1:0]     RESET_PC = '0,
   parameter logic [15:0]           NOP_WORD = 16'h0020
) (
   input  logic              clock,
   input  logic              reset,
   fetch_unit_if.master      bus,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_target,
   input  logic              halt
);

   typedef enum logic [1:0] {
      BOOT,
      FETCH,
      WAIT_FULL,
      HALTED
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              mem_rd_q, mem_rd_d;
   logic [15:0]       instr_q, instr_d;
   logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
   logic              instr_valid_q, instr_valid_d;
   logic              accept;

   // A word is taken only when no higher-priority event wins and the slot can move.
   assign accept = mem_rd_q && bus.mem_ready && !redirect_valid && !halt
                   && (!instr_valid_q || !bus.stall);

   assign bus.mem_addr    = pc_q;
   assign bus.mem_rd      = mem_rd_q;
   assign bus.instr       = instr_q;
   assign bus.instr_pc    = instr_pc_q;
   assign bus.instr_valid = instr_valid_q;

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= BOOT;
         pc_q          <= RESET_PC;
         mem_rd_q      <= 1'b0;
         instr_q       <= NOP_WORD;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         mem_rd_q      <= mem_rd_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   // Next-state selection: halt beats redirect beats normal sequencing.
   always_comb begin
      state_d = state_q;
      if (halt) begin
         state_d = HALTED;
      end else if (redirect_valid) begin
         state_d = FETCH;
      end else begin
         unique case (state_q)
            BOOT:      state_d = FETCH;
            FETCH:     if (instr_valid_q && bus.stall && !accept) state_d = WAIT_FULL;
            WAIT_FULL: if (!bus.stall) state_d = FETCH;
            HALTED:    state_d = HALTED;
            default:   state_d = BOOT;
         endcase
      end
   end

   // PC, fetch request and slot updates for the current state and events.
   always_comb begin
      pc_d          = pc_q;
      mem_rd_d      = mem_rd_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      if (halt) begin
         mem_rd_d      = 1'b0;
         instr_d       = NOP_WORD;
         instr_pc_d    = '0;
         instr_valid_d = 1'b0;
      end else if (redirect_valid) begin
         pc_d          = redirect_target;
         mem_rd_d      = 1'b1;
         instr_d       = NOP_WORD;
         instr_pc_d    = '0;
         instr_valid_d = 1'b0;
      end else begin
         unique case (state_q)
            BOOT: mem_rd_d = 1'b1;
            FETCH: begin
               if (accept) begin
                  instr_d       = bus.mem_rdata;
                  instr_pc_d    = pc_q;
                  instr_valid_d = 1'b1;
                  pc_d          = pc_q + ADDR_W'(1);
               end else if (instr_valid_q && !bus.stall) begin
                  instr_d       = NOP_WORD;
                  instr_valid_d = 1'b0;
               end else if (instr_valid_q && bus.stall) begin
                  mem_rd_d = 1'b0;
               end
            end
            WAIT_FULL: begin
               if (!bus.stall) begin
                  mem_rd_d      = 1'b1;
                  instr_d       = NOP_WORD;
                  instr_valid_d = 1'b0;
               end
            end
            HALTED:  mem_rd_d = 1'b0;
            default: mem_rd_d = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle table plus wait-state, halt and reset sequences.
module tb_fetch_unit;
   localparam int unsigned ADDR_W = 16;

   typedef struct packed {
      logic        stall;
      logic        rv;
      logic [15:0] tgt;
      logic        hlt;
      logic [15:0] e_addr;
      logic        e_rd;
      logic [15:0] e_instr;
      logic [15:0] e_pc;
      logic        e_valid;
   } vec_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [15:0] redirect_target = '0;
   logic        halt = 1'b0;

   int unsigned wait_states = 0;
   logic [15:0] trk_addr_q = '0;
   logic        trk_valid_q = 1'b0;
   int unsigned age_q = 0;

   int n_chk = 0;
   int n_fail = 0;

   vec_t tbl [25];

   fetch_unit_if #(.ADDR_W(ADDR_W)) mif ();

   fetch_unit #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (16'h0000),
      .NOP_WORD (16'h0020)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .bus             (mif.master),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .halt            (halt)
   );

   always #5 clock = ~clock;

   // Memory model: mem[a] = 16'h1000 + a; ready after wait_states cycles of a stable request.
   always @(posedge clock) begin
      trk_addr_q  <= mif.mem_addr;
      trk_valid_q <= mif.mem_rd;
      if (mif.mem_rd && trk_valid_q && mif.mem_addr == trk_addr_q) age_q <= age_q + 1;
      else age_q <= 0;
   end

   assign mif.mem_ready = mif.mem_rd && ((wait_states == 0) ||
                          (trk_valid_q && mif.mem_addr == trk_addr_q && age_q + 1 >= wait_states));
   assign mif.mem_rdata = mif.mem_ready ? 16'h1000 + mif.mem_addr : 16'hDEAD;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // instr_pc is only meaningful while the slot is valid.
   task automatic chk_out(input string tag, input logic [15:0] addr, input logic rd,
                          input logic [15:0] ins, input logic [15:0] pc, input logic valid);
      chk({tag, ".mem_addr"},    mif.mem_addr,           addr);
      chk({tag, ".mem_rd"},      16'(mif.mem_rd),        16'(rd));
      chk({tag, ".instr"},       mif.instr,              ins);
      chk({tag, ".instr_valid"}, 16'(mif.instr_valid),   16'(valid));
      if (valid) chk({tag, ".instr_pc"}, mif.instr_pc, pc);
   endtask

   task automatic drive(input logic st, input logic rv, input logic [15:0] tgt, input logic hl);
      mif.stall       = st;
      redirect_valid  = rv;
      redirect_target = tgt;
      halt            = hl;
   endtask

   initial begin
      //           stall rv   tgt       halt  addr      rd    instr     pc        valid
      tbl[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0020, 16'h0000, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b1, 16'h1000, 16'h0000, 1'b1};
      tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b1, 16'h1001, 16'h0001, 1'b1};
      tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0003, 1'b1, 16'h1002, 16'h0002, 1'b1};
      tbl[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 16'h1003, 16'h0003, 1'b1};
      tbl[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b0, 16'h1003, 16'h0003, 1'b1};
      tbl[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b0, 16'h1003, 16'h0003, 1'b1};
      tbl[7]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b0, 16'h1003, 16'h0003, 1'b1};
      tbl[8]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b0, 16'h1003, 16'h0003, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 16'h0020, 16'h0000, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0005, 1'b1, 16'h1004, 16'h0004, 1'b1};
      tbl[11] = '{1'b1, 1'b1, 16'h0040, 1'b0, 16'h0040, 1'b1, 16'h0020, 16'h0000, 1'b0};
      tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0041, 1'b1, 16'h1040, 16'h0040, 1'b1};
      tbl[13] = '{1'b0, 1'b1, 16'hFFFE, 1'b0, 16'hFFFE, 1'b1, 16'h0020, 16'h0000, 1'b0};
      tbl[14] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'hFFFF, 1'b1, 16'h0FFE, 16'hFFFE, 1'b1};
      tbl[15] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0FFF, 16'hFFFF, 1'b1};
      tbl[16] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b1, 16'h1000, 16'h0000, 1'b1};
      tbl[17] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0, 16'h0020, 16'h0000, 1'b0};
      tbl[18] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0, 16'h0020, 16'h0000, 1'b0};
      tbl[19] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b0, 16'h0020, 16'h0000, 1'b0};
      tbl[20] = '{1'b0, 1'b1, 16'h0100, 1'b0, 16'h0100, 1'b1, 16'h0020, 16'h0000, 1'b0};
      tbl[21] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0101, 1'b1, 16'h1100, 16'h0100, 1'b1};
      tbl[22] = '{1'b0, 1'b1, 16'h0200, 1'b1, 16'h0101, 1'b0, 16'h0020, 16'h0000, 1'b0};
      tbl[23] = '{1'b0, 1'b1, 16'h0100, 1'b0, 16'h0100, 1'b1, 16'h0020, 16'h0000, 1'b0};
      tbl[24] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0101, 1'b1, 16'h1100, 16'h0100, 1'b1};

      drive(1'b0, 1'b0, 16'h0000, 1'b0);
      @(negedge clock);
      @(negedge clock);
      chk_out("reset", 16'h0000, 1'b0, 16'h0020, 16'h0000, 1'b0);
      chk("reset.instr_pc", mif.instr_pc, 16'h0000);

      reset = 1'b1;
      for (int i = 0; i < 25; i++) begin
         drive(tbl[i].stall, tbl[i].rv, tbl[i].tgt, tbl[i].hlt);
         @(negedge clock);
         chk_out($sformatf("row%0d", i), tbl[i].e_addr, tbl[i].e_rd, tbl[i].e_instr,
                 tbl[i].e_pc, tbl[i].e_valid);
      end

      // Two wait states: one instruction every third cycle, address stable per access.
      wait_states = 2;
      drive(1'b0, 1'b1, 16'h0010, 1'b0);
      @(negedge clock);
      chk_out("ws_redir", 16'h0010, 1'b1, 16'h0020, 16'h0000, 1'b0);
      for (int k = 1; k <= 9; k++) begin
         drive(1'b0, 1'b0, 16'h0000, 1'b0);
         @(negedge clock);
         if (k % 3 == 0)
            chk_out($sformatf("ws%0d", k), 16'(16'h0010 + k / 3), 1'b1,
                    16'(16'h1010 + k / 3 - 1), 16'(16'h0010 + k / 3 - 1), 1'b1);
         else
            chk_out($sformatf("ws%0d", k), 16'(16'h0010 + k / 3), 1'b1,
                    16'h0020, 16'h0000, 1'b0);
      end
      @(negedge clock);
      chk_out("ws10", 16'h0013, 1'b1, 16'h0020, 16'h0000, 1'b0);

      // Halt in the middle of an access, then release without a redirect.
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, 1'b0, 16'h0000, (k < 2));
         @(negedge clock);
         chk_out($sformatf("park%0d", k), 16'h0013, 1'b0, 16'h0020, 16'h0000, 1'b0);
      end
      drive(1'b0, 1'b1, 16'h0100, 1'b0);
      @(negedge clock);
      chk_out("resume", 16'h0100, 1'b1, 16'h0020, 16'h0000, 1'b0);
      drive(1'b0, 1'b0, 16'h0000, 1'b0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clock);
         chk_out($sformatf("resume_w%0d", k), 16'h0100, 1'b1, 16'h0020, 16'h0000, 1'b0);
      end
      @(negedge clock);
      chk_out("resume_data", 16'h0101, 1'b1, 16'h1100, 16'h0100, 1'b1);

      // Reset asserted between edges while fetching.
      wait_states = 0;
      @(negedge clock);
      chk_out("pre_rst", 16'h0102, 1'b1, 16'h1101, 16'h0101, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk_out("rst_async", 16'h0000, 1'b0, 16'h0020, 16'h0000, 1'b0);
      chk("rst_async.instr_pc", mif.instr_pc, 16'h0000);
      @(negedge clock);
      chk_out("rst_hold", 16'h0000, 1'b0, 16'h0020, 16'h0000, 1'b0);
      reset = 1'b1;
      @(negedge clock);
      chk_out("rst_boot", 16'h0000, 1'b1, 16'h0020, 16'h0000, 1'b0);
      @(negedge clock);
      chk_out("rst_first", 16'h0001, 1'b1, 16'h1000, 16'h0000, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
